// File: rtl/move_step_scheduler_pkg.sv
// Shared encodings for the snake game: master game state, headings and step-scheduler debug state.
package move_step_scheduler_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_WIN  = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        CS_IDLE     = 2'b00,
        CS_RUN      = 2'b01,
        CS_WAIT_ACK = 2'b10,
        CS_HALT     = 2'b11
    } ctrl_state_e;

    // Opposite headings differ only in the low bit (up/down, left/right).
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/move_step_scheduler_direction_arbiter.sv
// Turns fresh button presses into a pending heading: edge detect, reversal filter,
// fixed priority up>down>left>right, last accepted press wins.
import move_step_scheduler_pkg::*;

module direction_arbiter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] btn_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  dir_e       dir_i,
    output dir_e       pend_o
);

    logic [3:0] btn_q;
    logic [3:0] cand;
    logic       win;
    dir_e       sel;
    dir_e       pend_q;
    dir_e       pend_d;

    // Button bit index equals the heading code, so the reversal mask is a one-hot shift.
    always_comb begin
        cand = btn_i & ~btn_q & ~(4'b0001 << reverse_dir(dir_i));
        win  = 1'b0;
        sel  = DIR_UP;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) begin
                win = 1'b1;
                sel = dir_e'(i[1:0]);
            end
        end
        pend_o = (en_i && win) ? sel : pend_q;
        pend_d = clr_i ? DIR_RIGHT : pend_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_q  <= 4'b0000;
            pend_q <= DIR_RIGHT;
        end else begin
            btn_q  <= btn_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/move_step_scheduler.sv
// Snake step scheduler: score-scaled step timer, request/ack handshake with overrun
// detection, and game-mode control around a buffered heading.
import move_step_scheduler_pkg::*;

module move_step_scheduler #(
    parameter int BASE_PERIOD = 5000000,
    parameter int STEP_DEC    = 400000,
    parameter int MIN_PERIOD  = 1000000,
    parameter int CNT_W       = 23
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] STATE_IN,
    input  logic [3:0] PUSH_BUTTONS,
    input  logic [3:0] SCORE_IN,
    input  logic       STEP_ACK,
    output logic       STEP_REQ,
    output logic [1:0] DIRECTION_OUT,
    output logic       OVERRUN,
    output logic [1:0] CTRL_STATE
);

    localparam int PW = CNT_W + 4;
    localparam logic signed [PW-1:0] PW_BASE = PW'(BASE_PERIOD);
    localparam logic signed [PW-1:0] PW_DEC  = PW'(STEP_DEC);
    localparam logic signed [PW-1:0] PW_MIN  = PW'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]     ONE     = CNT_W'(1);

    // Signed headroom lets BASE - score*DEC go negative before the floor clamps it.
    function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] score);
        logic signed [PW-1:0] p;
        p = PW_BASE - $signed({{(PW-4){1'b0}}, score}) * PW_DEC;
        if (p < PW_MIN) p = PW_MIN;
        return p[CNT_W-1:0];
    endfunction

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             req_q, req_d;
    dir_e             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    dir_e             pend;
    logic             term;
    logic             arb_en;

    assign arb_en = (state_q == CS_RUN) || (state_q == CS_WAIT_ACK);

    direction_arbiter u_arb (
        .clk_i  (CLOCK),
        .rst_ni (RESET),
        .btn_i  (PUSH_BUTTONS),
        .en_i   (arb_en),
        .clr_i  (state_d == CS_IDLE),
        .dir_i  (dir_q),
        .pend_o (pend)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        req_d    = req_q;
        dir_d    = dir_q;
        ovr_d    = ovr_q;
        term     = (timer_q == period_q - ONE);

        if (STATE_IN == GS_WIN) begin
            state_d = CS_HALT;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                CS_IDLE: if (STATE_IN == GS_PLAY) state_d = CS_RUN;
                CS_HALT: if (STATE_IN == GS_IDLE) state_d = CS_IDLE;
                CS_RUN: begin
                    if (STATE_IN == GS_IDLE) begin
                        state_d = CS_IDLE;
                    end else if (term) begin
                        dir_d    = pend;
                        req_d    = 1'b1;
                        timer_d  = '0;
                        period_d = calc_period(SCORE_IN);
                        state_d  = CS_WAIT_ACK;
                    end else begin
                        timer_d = timer_q + ONE;
                    end
                end
                default: begin
                    if (STATE_IN == GS_IDLE) begin
                        state_d = CS_IDLE;
                    end else if (term) begin
                        timer_d  = '0;
                        period_d = calc_period(SCORE_IN);
                        // A tick that meets an ack (or a re-issue slot) commits; otherwise it is dropped.
                        if (!req_q || STEP_ACK) begin
                            dir_d = pend;
                            req_d = !req_q;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + ONE;
                        if (!req_q) begin
                            req_d = 1'b1;
                        end else if (STEP_ACK) begin
                            req_d   = 1'b0;
                            state_d = CS_RUN;
                        end
                    end
                end
            endcase
        end

        if (state_d == CS_IDLE) begin
            timer_d  = '0;
            req_d    = 1'b0;
            dir_d    = DIR_RIGHT;
            ovr_d    = 1'b0;
            period_d = calc_period(SCORE_IN);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= CS_IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            dir_q   <= DIR_RIGHT;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        period_q <= period_d;
    end

    assign STEP_REQ      = req_q;
    assign DIRECTION_OUT = dir_q;
    assign OVERRUN       = ovr_q;
    assign CTRL_STATE    = state_q;

endmodule

// File: tb/tb_move_step_scheduler.sv
// Bench for move_step_scheduler: directed scenarios plus randomized traffic, checked
// against a behavioural model of the step/steer/mode rules.
module tb_move_step_scheduler;

    localparam int BASE = 20;
    localparam int DEC  = 3;
    localparam int MINP = 8;
    localparam int CW   = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] st    = 2'b00;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] score = 4'd0;
    logic       ack   = 1'b0;
    logic       req;
    logic [1:0] dir;
    logic       ovr;
    logic [1:0] cs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    move_step_scheduler #(
        .BASE_PERIOD (BASE),
        .STEP_DEC    (DEC),
        .MIN_PERIOD  (MINP),
        .CNT_W       (CW)
    ) dut (
        .CLOCK         (clk),
        .RESET         (rst_n),
        .STATE_IN      (st),
        .PUSH_BUTTONS  (btn),
        .SCORE_IN      (score),
        .STEP_ACK      (ack),
        .STEP_REQ      (req),
        .DIRECTION_OUT (dir),
        .OVERRUN       (ovr),
        .CTRL_STATE    (cs)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 wait-ack, 3 halt; m_el = cycles since last reload.
    int         m_mode, m_el, m_per;
    logic       m_req, m_ovr;
    logic [1:0] m_dir, m_pend;
    logic [3:0] m_prev;

    bit auto_ack   = 1'b0;
    bit rose       = 1'b0;
    int last_rise  = 0;
    int rise_gap   = 0;
    int dev        = 0;

    function automatic int per_of(input int s);
        int p;
        p = BASE - s * DEC;
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_req, m_dir, m_ovr, m_mode[1:0]};
    endfunction

    function automatic logic [5:0] got_vec();
        return {req, dir, ovr, cs};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_per = per_of(0);
        m_req = 1'b0; m_ovr = 1'b0; m_dir = 2'b11; m_pend = 2'b11; m_prev = 4'b0000;
    endtask

    task automatic go_idle();
        m_mode = 0; m_el = 0; m_req = 1'b0; m_dir = 2'b11; m_pend = 2'b11;
        m_ovr = 1'b0; m_per = per_of(int'(score));
    endtask

    task automatic model_step();
        logic [3:0] rise;
        logic [1:0] pnow;
        int  win;
        bit  act, tick_now;
        if (!rst_n) begin
            model_reset();
            return;
        end
        act  = (m_mode == 1) || (m_mode == 2);
        rise = btn & ~m_prev;
        win  = -1;
        if (act)
            for (int i = 0; i < 4; i++)
                if (win < 0 && rise[i] && i != int'(m_dir ^ 2'b01)) win = i;
        pnow     = (win >= 0) ? 2'(win) : m_pend;
        m_prev   = btn;
        tick_now = (m_el == m_per - 1);
        if (st == 2'b10) begin
            if (act) m_pend = pnow;
            m_mode = 3; m_req = 1'b0;
        end else if (m_mode == 3) begin
            if (st == 2'b00) go_idle();
        end else if (m_mode == 0) begin
            go_idle();
            if (st == 2'b01) m_mode = 1;
        end else if (st == 2'b00) begin
            go_idle();
        end else begin
            m_pend = pnow;
            if (m_mode == 1) begin
                if (tick_now) begin
                    m_dir = pnow; m_req = 1'b1; m_el = 0; m_per = per_of(int'(score)); m_mode = 2;
                end else m_el++;
            end else if (tick_now) begin
                m_el = 0; m_per = per_of(int'(score));
                if (!m_req)        begin m_dir = pnow; m_req = 1'b1; end
                else if (ack)      begin m_dir = pnow; m_req = 1'b0; end
                else               m_ovr = 1'b1;
            end else begin
                m_el++;
                if (!m_req)   m_req = 1'b1;
                else if (ack) begin m_req = 1'b0; m_mode = 1; end
            end
        end
    endtask

    task automatic tick();
        logic was;
        if (auto_ack) ack = m_req;
        was = req;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        rose = 1'b0;
        if (!was && req) begin
            rose = 1'b1;
            rise_gap = cyc - last_rise;
            last_rise = cyc;
        end
        if (got_vec() !== exp_vec()) dev++;
    endtask

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rose) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_vec() !== 6'b011000) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", got_vec(), 6'b011000);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (got_vec() !== 6'b011000) begin
            failures++;
            $display("FAIL reset_idle got=%b want=%b", got_vec(), 6'b011000);
        end
    endtask

    task automatic test_basic();
        bit ok;
        auto_ack = 1'b1;
        st = 2'b01;
        score = 4'd0;
        wait_rise(ok);
        for (int k = 0; k < 3; k++) begin
            wait_rise(ok);
            checks++;
            if (!ok || rise_gap != 20 || dir !== 2'b11) begin
                failures++;
                $display("FAIL basic_step k=%0d gap=%0d dir=%b want gap=20 dir=11", k, rise_gap, dir);
            end
        end
        checks++;
        if (dev != 0) begin
            failures++;
            $display("FAIL basic_model deviations=%0d want 0", dev);
        end
    endtask

    task automatic test_period();
        bit ok;
        int want[4] = '{20, 14, 14, 8};
        wait_rise(ok);
        for (int k = 0; k < 4; k++) begin
            if (k == 0 || k == 2) begin
                repeat (3) tick();
                score = (k == 0) ? 4'd2 : 4'd9;
            end
            wait_rise(ok);
            checks++;
            if (!ok || rise_gap != want[k]) begin
                failures++;
                $display("FAIL period k=%0d gap=%0d want=%0d", k, rise_gap, want[k]);
            end
        end
        wait_rise(ok);
        checks++;
        if (!ok || rise_gap != 8 || dev != 0) begin
            failures++;
            $display("FAIL period_floor gap=%0d dev=%0d want gap=8 dev=0", rise_gap, dev);
        end
    endtask

    task automatic test_steer();
        bit ok;
        logic [3:0] presses[4] = '{4'b0100, 4'b0101, 4'b0110, 4'b1010};
        logic [1:0] want[4]    = '{2'b00, 2'b00, 2'b10, 2'b01};
        score = 4'd0;
        wait_rise(ok);
        wait_rise(ok);
        for (int k = 0; k < 4; k++) begin
            tick();
            btn = presses[k];
            tick();
            btn = 4'b0000;
            tick();
            if (k == 0) begin
                btn = 4'b0001;
                tick();
                btn = 4'b0000;
            end
            wait_rise(ok);
            checks++;
            if (!ok || dir !== want[k]) begin
                failures++;
                $display("FAIL steer k=%0d dir=%b want=%b", k, dir, want[k]);
            end
        end
        checks++;
        if (dev != 0) begin
            failures++;
            $display("FAIL steer_model deviations=%0d want 0", dev);
        end
    endtask

    task automatic test_collision();
        bit ok, hit;
        wait_rise(ok);
        auto_ack = 1'b0;
        ack = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_mode == 2 && m_el == m_per - 1) begin
                ack = 1'b1;
                hit = 1'b1;
            end
            tick();
        end
        ack = 1'b0;
        checks++;
        if (!hit || req !== 1'b0 || ovr !== 1'b0 || cs !== 2'b10) begin
            failures++;
            $display("FAIL collision_low hit=%0d req=%b ovr=%b cs=%b want req=0 ovr=0 cs=10", hit, req, ovr, cs);
        end
        tick();
        checks++;
        if (req !== 1'b1 || ovr !== 1'b0) begin
            failures++;
            $display("FAIL collision_reissue req=%b ovr=%b want req=1 ovr=0", req, ovr);
        end
        auto_ack = 1'b1;
    endtask

    task automatic test_overrun();
        bit ok;
        int first = -1;
        int drops = 0;
        wait_rise(ok);
        auto_ack = 1'b0;
        ack = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (ovr === 1'b1 && first < 0) first = i;
            if (req !== 1'b1) drops++;
        end
        checks++;
        if (first != 20 || drops != 0) begin
            failures++;
            $display("FAIL overrun first_cycle=%0d req_drops=%0d want 20 and 0", first, drops);
        end
    endtask

    task automatic test_mode();
        bit ok;
        logic [1:0] held;
        st = 2'b10;
        tick();
        checks++;
        if (cs !== 2'b11 || req !== 1'b0 || ovr !== 1'b1) begin
            failures++;
            $display("FAIL halt_entry cs=%b req=%b ovr=%b want 11 0 1", cs, req, ovr);
        end
        held = m_dir;
        btn = 4'b0001;
        tick();
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        tick();
        checks++;
        if (dir !== held || cs !== 2'b11) begin
            failures++;
            $display("FAIL halt_frozen dir=%b cs=%b want %b 11", dir, cs, held);
        end
        st = 2'b00;
        tick();
        checks++;
        if (cs !== 2'b00 || ovr !== 1'b0 || dir !== 2'b11 || req !== 1'b0) begin
            failures++;
            $display("FAIL idle_entry cs=%b ovr=%b dir=%b req=%b want 00 0 11 0", cs, ovr, dir, req);
        end
        st = 2'b01;
        auto_ack = 1'b1;
        wait_rise(ok);
        auto_ack = 1'b0;
        ack = 1'b0;
        repeat (5) tick();
        checks++;
        if (!ok || req !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_req req=%b want 1", req);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_vec() !== 6'b011000) begin
            failures++;
            $display("FAIL reset_mid got=%b want=%b", got_vec(), 6'b011000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (dev != 0) begin
            failures++;
            $display("FAIL mode_model deviations=%0d want 0", dev);
        end
    endtask

    task automatic test_random();
        int r;
        auto_ack = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0)      st = 2'b00;
            else if (r == 1) st = 2'b10;
            else if (r < 5)  st = 2'b11;
            else             st = 2'b01;
            btn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 29) == 0) score = 4'($urandom);
            ack = m_req && ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_period();
        test_steer();
        test_collision();
        test_overrun();
        test_mode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
